stack_ctrl: RTL

//  Push/pop sequencer that sits directly upstream of the stack pointer (SP) register.

---
 rtl/stack_pkg.sv | 26 ++
 rtl/stack_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stack_pkg.sv
// ============================================================================
// Module   : stack_pkg
// Purpose  : Shared encodings and defaults for the stack push/pop sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_PUSH    = 3'd1;
    localparam state_t S_POP_RD  = 3'd2;
    localparam state_t S_POP_CAP = 3'd3;
    localparam state_t S_RESP    = 3'd4;

    localparam logic [15:0] SP_TOP_DEF   = 16'h01FF;
    localparam logic [15:0] SP_LIMIT_DEF = 16'h0100;

endpackage

`default_nettype wire

// File: rtl/stack_ctrl.sv
// ============================================================================
// Module   : stack_ctrl
// Purpose  : Push/pop sequencer driving stack RAM and external SP inc/dec.
//            Optional high-water mark register enabled by STACK_CTRL_HWM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ctrl
    import stack_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int          DW       = 16,
    parameter logic [AW-1:0] SP_TOP   = SP_TOP_DEF,
    parameter logic [AW-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_op,
    input  logic [DW-1:0] req_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    input  logic [AW-1:0] sp_in,
    output logic          sp_inc,
    output logic          sp_dec,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] hwm
);

    localparam logic [AW-1:0] ONE     = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] SP_FULL = SP_LIMIT - ONE;

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_data;
    logic          w_accept;
    logic          w_err;
    logic [AW-1:0] w_sp_below;

    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_err      = (req_op == OP_PUSH) ? (sp_in == SP_FULL) : (sp_in == SP_TOP);
    assign w_sp_below = sp_in - ONE;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_next_state = S_RESP;
                    end else if (req_op == OP_PUSH) begin
                        w_next_state = S_PUSH;
                    end else begin
                        w_next_state = S_POP_RD;
                    end
                end
            end
            S_PUSH:    w_next_state = S_RESP;
            S_POP_RD:  w_next_state = S_POP_CAP;
            S_POP_CAP: w_next_state = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output decode; RAM and SP strobes exist only in their one-cycle states
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_PUSH: begin
                mem_we    = 1'b1;
                mem_addr  = sp_in;
                mem_wdata = r_data;
                sp_dec    = 1'b1;
            end
            S_POP_RD: begin
                mem_re   = 1'b1;
                mem_addr = sp_in + ONE;
                sp_inc   = 1'b1;
            end
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Hold registers; resp_data is cleared on accept so pushes and errors return 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (w_accept) begin
            r_data    <= req_data;
            resp_data <= '0;
            resp_err  <= w_err;
        end else if (r_state == S_POP_CAP) begin
            resp_data <= mem_rdata;
        end
    end

`ifdef STACK_CTRL_HWM_EN
    logic [AW-1:0] r_hwm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hwm <= SP_TOP;
        end else if ((r_state == S_PUSH) && (w_sp_below < r_hwm)) begin
            r_hwm <= w_sp_below;
        end
    end

    assign hwm = r_hwm;
`else
    logic w_unused;
    assign w_unused = ^w_sp_below;
    assign hwm      = SP_TOP;
`endif

endmodule

`default_nettype wire
